// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing memory port B between NUM_REQ requesters.
// One transaction in flight: IDLE grants, ISSUE pulses the enables, WAIT holds for done.
module mem_port_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int MAIN_RAM_SIZE = 4096,
    parameter int ADDR_W        = $clog2(MAIN_RAM_SIZE)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]       req_data_i,
    input  logic [NUM_REQ*4-1:0]        req_data_en,
    input  logic [NUM_REQ-1:0]          req_write_en,
    input  logic [NUM_REQ-1:0]          req_read_en,
    output logic [NUM_REQ*32-1:0]       req_data_o,
    output logic [NUM_REQ-1:0]          req_done,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [31:0]                 mem_data_i,
    output logic [3:0]                  mem_data_en,
    output logic                        mem_write_en,
    output logic                        mem_read_en,
    input  logic [31:0]                 mem_data_o,
    input  logic                        mem_done,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     lastGrant_q, lastGrant_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [31:0]       memWdata_q, memWdata_d;
    logic [3:0]        memBe_q, memBe_d;
    logic              memRe_q, memRe_d;
    logic              memWe_q, memWe_d;
    logic              isRead_q, isRead_d;

    logic [ADDR_W-1:0] reqAddrArr  [NUM_REQ];
    logic [31:0]       reqWdataArr [NUM_REQ];
    logic [3:0]        reqBeArr    [NUM_REQ];
    logic [NUM_REQ-1:0] pending;
    logic [GW-1:0]     scanIdx;
    logic [GW-1:0]     winner;
    logic              winFound;
    logic              doneHit;

    for (genvar g = 0; g < NUM_REQ; g++) begin : gUnpack
        assign reqAddrArr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign reqWdataArr[g] = req_data_i[g*32 +: 32];
        assign reqBeArr[g]    = req_data_en[g*4 +: 4];
        // Write-only completions return zero rather than the memory's read bus.
        assign req_data_o[g*32 +: 32] = (req_done[g] && isRead_q) ? mem_data_o : 32'h0;
    end

    assign pending = req_read_en | req_write_en;

    // Scan from the requester after the last winner so every index gets a turn.
    always_comb begin
        winFound = 1'b0;
        winner   = '0;
        scanIdx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scanIdx = GW'((int'(lastGrant_q) + k) % NUM_REQ);
            if (!winFound && pending[scanIdx]) begin
                winFound = 1'b1;
                winner   = scanIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lastGrant_q <= GW'(NUM_REQ - 1);
            grant_q     <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memBe_q     <= '0;
            memRe_q     <= 1'b0;
            memWe_q     <= 1'b0;
            isRead_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memBe_q     <= memBe_d;
            memRe_q     <= memRe_d;
            memWe_q     <= memWe_d;
            isRead_q    <= isRead_d;
        end
    end

    // Address/data/byte-enables keep their last value; only the enables are pulsed.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        memBe_d     = memBe_q;
        memRe_d     = memRe_q;
        memWe_d     = memWe_q;
        isRead_d    = isRead_q;
        case (state_q)
            S_IDLE: begin
                if (winFound) begin
                    grant_d    = winner;
                    memAddr_d  = reqAddrArr[winner];
                    memWdata_d = reqWdataArr[winner];
                    memBe_d    = reqBeArr[winner];
                    memRe_d    = req_read_en[winner];
                    memWe_d    = req_write_en[winner];
                    isRead_d   = req_read_en[winner];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                memRe_d = 1'b0;
                memWe_d = 1'b0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_done) begin
                    lastGrant_d = grant_q;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                memRe_d = 1'b0;
                memWe_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        doneHit  = (state_q == S_WAIT) && mem_done;
        req_done = '0;
        if (doneHit) begin
            req_done = NUM_REQ'(1) << grant_q;
        end
    end

    assign grant_id     = grant_q;
    assign mem_addr     = memAddr_q;
    assign mem_data_i   = memWdata_q;
    assign mem_data_en  = memBe_q;
    assign mem_read_en  = memRe_q;
    assign mem_write_en = memWe_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural port-B memory
// whose done latency can be stretched to exercise reset during WAIT.
module tb_mem_port_arbiter;

    localparam int NR = 2;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*32-1:0]  req_data_i;
    logic [NR*4-1:0]   req_data_en;
    logic [NR-1:0]     req_write_en;
    logic [NR-1:0]     req_read_en;
    logic [NR*32-1:0]  req_data_o;
    logic [NR-1:0]     req_done;
    logic [AW-1:0]     mem_addr;
    logic [31:0]       mem_data_i;
    logic [3:0]        mem_data_en;
    logic              mem_write_en;
    logic              mem_read_en;
    logic [31:0]       mem_data_o;
    logic              mem_done;
    logic              busy;
    logic [0:0]        grant_id;

    logic [AW-1:0]     addrA  [NR];
    logic [31:0]       wdataA [NR];
    logic [3:0]        beA    [NR];
    logic [NR-1:0]     rdV;
    logic [NR-1:0]     wrV;

    logic [31:0]       memArr [1024];
    logic [31:0]       memRdata = 32'h0;
    logic              memDone = 1'b0;
    int                memCnt = 0;
    int                memDelay;
    logic              preloadEn;
    logic [AW-1:0]     preloadAddr;
    logic [31:0]       preloadData;

    int checks = 0;
    int failures = 0;

    assign req_addr     = {addrA[1], addrA[0]};
    assign req_data_i   = {wdataA[1], wdataA[0]};
    assign req_data_en  = {beA[1], beA[0]};
    assign req_read_en  = rdV;
    assign req_write_en = wrV;
    assign mem_data_o   = memRdata;
    assign mem_done     = memDone;

    mem_port_arbiter #(
        .NUM_REQ (NR),
        .ADDR_W  (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_addr     (req_addr),
        .req_data_i   (req_data_i),
        .req_data_en  (req_data_en),
        .req_write_en (req_write_en),
        .req_read_en  (req_read_en),
        .req_data_o   (req_data_o),
        .req_done     (req_done),
        .mem_addr     (mem_addr),
        .mem_data_i   (mem_data_i),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_data_o   (mem_data_o),
        .mem_done     (mem_done),
        .busy         (busy),
        .grant_id     (grant_id)
    );

    always #5 clk = ~clk;

    // Port-B memory: returns the pre-write word and signals done memDelay cycles after sampling.
    always @(posedge clk) begin
        memDone <= 1'b0;
        if (memCnt > 0) begin
            memCnt <= memCnt - 1;
            if (memCnt == 1) memDone <= 1'b1;
        end
        if (preloadEn) memArr[preloadAddr[AW-1:2]] <= preloadData;
        if (mem_read_en || mem_write_en) begin
            memRdata <= memArr[mem_addr[AW-1:2]];
            if (mem_write_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_data_en[b]) memArr[mem_addr[AW-1:2]][b*8 +: 8] <= mem_data_i[b*8 +: 8];
                end
            end
            if (memDelay <= 1) memDone <= 1'b1;
            else memCnt <= memDelay - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic rd, input logic wr,
                                 input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        addrA[idx]  = a;
        wdataA[idx] = d;
        beA[idx]    = be;
        rdV[idx]    = rd;
        wrV[idx]    = wr;
    endtask

    task automatic clearReq(input int idx);
        rdV[idx] = 1'b0;
        wrV[idx] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got time limit expected finish");
        $fatal(1, "[TB] bench did not finish");
    end

    initial begin
        memDelay    = 1;
        preloadEn   = 1'b0;
        preloadAddr = '0;
        preloadData = '0;
        for (int i = 0; i < NR; i++) begin
            addrA[i]  = '0;
            wdataA[i] = '0;
            beA[i]    = '0;
        end
        rdV   = '0;
        wrV   = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_busy",   64'(busy), 64'h0);
        checkOutput("rst_grant",  64'(grant_id), 64'h0);
        checkOutput("rst_re",     64'(mem_read_en), 64'h0);
        checkOutput("rst_we",     64'(mem_write_en), 64'h0);
        checkOutput("rst_addr",   64'(mem_addr), 64'h0);
        checkOutput("rst_wdata",  64'(mem_data_i), 64'h0);
        checkOutput("rst_be",     64'(mem_data_en), 64'h0);
        checkOutput("rst_done",   64'(req_done), 64'h0);
        checkOutput("rst_rdata",  64'(req_data_o), 64'h0);

        preloadEn   = 1'b1;
        preloadAddr = 12'h100;
        preloadData = 32'hDEADBEEF;
        reset       = 1'b0;
        tick();
        preloadEn = 1'b0;

        $display("[TB] single read");
        applyStimulus(0, 1'b1, 1'b0, 12'h102, 32'h0, 4'h0);
        tick();
        checkOutput("rd_issue_re",   64'(mem_read_en), 64'h1);
        checkOutput("rd_issue_we",   64'(mem_write_en), 64'h0);
        checkOutput("rd_issue_addr", 64'(mem_addr), 64'h102);
        checkOutput("rd_issue_busy", 64'(busy), 64'h1);
        checkOutput("rd_issue_gnt",  64'(grant_id), 64'h0);
        tick();
        checkOutput("rd_wait_re",    64'(mem_read_en), 64'h0);
        checkOutput("rd_done",       64'(req_done), 64'h1);
        checkOutput("rd_data0",      64'(req_data_o[31:0]), 64'hDEADBEEF);
        checkOutput("rd_data1",      64'(req_data_o[63:32]), 64'h0);
        clearReq(0);
        tick();
        checkOutput("rd_idle_done",  64'(req_done), 64'h0);
        checkOutput("rd_idle_busy",  64'(busy), 64'h0);
        checkOutput("rd_addr_hold",  64'(mem_addr), 64'h102);

        $display("[TB] byte write then read");
        applyStimulus(1, 1'b0, 1'b1, 12'h100, 32'h11223344, 4'b0101);
        tick();
        checkOutput("bw_issue_we",   64'(mem_write_en), 64'h1);
        checkOutput("bw_issue_re",   64'(mem_read_en), 64'h0);
        checkOutput("bw_issue_data", 64'(mem_data_i), 64'h11223344);
        checkOutput("bw_issue_be",   64'(mem_data_en), 64'h5);
        checkOutput("bw_issue_gnt",  64'(grant_id), 64'h1);
        tick();
        checkOutput("bw_done",       64'(req_done), 64'h2);
        checkOutput("bw_rdata_zero", 64'(req_data_o), 64'h0);
        clearReq(1);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("bw_rb_done",    64'(req_done), 64'h1);
        checkOutput("bw_rb_data",    64'(req_data_o[31:0]), 64'hDE22BE44);
        clearReq(0);
        tick();

        $display("[TB] contention from reset");
        reset = 1'b1;
        tick();
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        applyStimulus(1, 1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("ct_gnt%0d", t), 64'(grant_id), 64'(t % 2));
            tick();
            checkOutput($sformatf("ct_done%0d", t), 64'(req_done), (t % 2 == 0) ? 64'h1 : 64'h2);
            if (t == 3) begin
                clearReq(0);
                clearReq(1);
            end
            tick();
            checkOutput($sformatf("ct_gap%0d", t), 64'(req_done), 64'h0);
            checkOutput($sformatf("ct_busy%0d", t), 64'(busy), 64'h0);
        end

        $display("[TB] read and write together");
        preloadEn   = 1'b1;
        preloadAddr = 12'h100;
        preloadData = 32'hDEADBEEF;
        tick();
        preloadEn = 1'b0;
        applyStimulus(0, 1'b1, 1'b1, 12'h100, 32'hCAFEF00D, 4'hF);
        tick();
        checkOutput("rw_issue_en",   64'({mem_read_en, mem_write_en}), 64'h3);
        tick();
        checkOutput("rw_done",       64'(req_done), 64'h1);
        checkOutput("rw_old_data",   64'(req_data_o[31:0]), 64'hDEADBEEF);
        clearReq(0);
        tick();
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("rw_new_data",   64'(req_data_o[31:0]), 64'hCAFEF00D);
        clearReq(0);
        tick();

        $display("[TB] late arrival");
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("la_done0",      64'(req_done), 64'h1);
        checkOutput("la_busy_wait",  64'(busy), 64'h1);
        clearReq(0);
        applyStimulus(1, 1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
        tick();
        checkOutput("la_busy_gap",   64'(busy), 64'h0);
        tick();
        checkOutput("la_busy_back",  64'(busy), 64'h1);
        checkOutput("la_gnt1",       64'(grant_id), 64'h1);
        checkOutput("la_re1",        64'(mem_read_en), 64'h1);
        tick();
        checkOutput("la_done1",      64'(req_done), 64'h2);
        clearReq(1);
        tick();

        $display("[TB] reset during WAIT");
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("pre_done0",     64'(req_data_o[31:0]), 64'hCAFEF00D);
        clearReq(0);
        tick();
        memDelay = 3;
        applyStimulus(0, 1'b1, 1'b0, 12'h100, 32'h0, 4'h0);
        tick();
        checkOutput("rw_gnt0",       64'(grant_id), 64'h0);
        tick();
        checkOutput("rwt_nodone",    64'(req_done), 64'h0);
        checkOutput("rwt_busy",      64'(busy), 64'h1);
        reset = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, 12'h104, 32'h0, 4'h0);
        tick();
        checkOutput("rwt_rst_done",  64'(req_done), 64'h0);
        checkOutput("rwt_rst_busy",  64'(busy), 64'h0);
        checkOutput("rwt_rst_en",    64'({mem_read_en, mem_write_en}), 64'h0);
        checkOutput("rwt_rst_addr",  64'(mem_addr), 64'h0);
        checkOutput("rwt_rst_gnt",   64'(grant_id), 64'h0);
        reset    = 1'b0;
        memDelay = 1;
        tick();
        checkOutput("rwt_regrant",   64'(grant_id), 64'h0);
        checkOutput("rwt_issue_re",  64'(mem_read_en), 64'h1);
        checkOutput("rwt_ign_done",  64'(req_done), 64'h0);
        tick();
        checkOutput("rwt_done0",     64'(req_done), 64'h1);
        checkOutput("rwt_data0",     64'(req_data_o[31:0]), 64'hCAFEF00D);
        clearReq(0);
        tick();
        tick();
        checkOutput("rwt_gnt1",      64'(grant_id), 64'h1);
        tick();
        checkOutput("rwt_done1",     64'(req_done), 64'h2);
        clearReq(1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
